mod_mult_pair_acc: RTL and testbench
====================================

# mod_mult_pair_acc

Pipelined multiply-and-pair-sum stage that sits directly upstream of `mod_reduct`. It takes a stream of MOD_W-bit operand pairs (x, y), forms each product, and sums consecutive products two by two. Each sum is emitted as one unreduced OP_W = 2*MOD_W+1 word, which `mod_reduct` consumes with no adaptation. A `last` marker flushes an odd trailing product alone, so dot-product chunks of any length reduce correctly.

## Interface
- MOD_W, 33, operand width.
- OP_W, 2*MOD_W+1, output width. Fixed by construction; `$fatal` at elaboration if a different value is passed.
- IN_PIPE, 1, 1 adds an input register stage.
- SIDE_W, 0, side-data width; 0 means unused.
- RST_SIDE, 2'b00, side reset value: [0]=1 resets side to 0, [1]=1 resets side to 1, neither set means side is not reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_x  in  MOD_W  operand x.
- in_y  in  MOD_W  operand y.
- in_last  in  1  element closes the current chunk.
- in_avail  in  1  input valid qualifier.
- in_side  in  SIDE_W  side data travelling with the element.
- z  out  OP_W  sum of products (unreduced).
- out_single  out  1  z holds exactly one product (odd flush).
- out_avail  out  1  z valid, one-cycle pulse.
- out_side  out  SIDE_W  side data of the closing element.

## Operation
- There is no backpressure. An input is accepted on every cycle in which `in_avail`=1. Output is a one-cycle `out_avail` pulse, the same contract `mod_reduct` uses.
- Stage S0 exists only when IN_PIPE=1. It registers x, y, last, avail and side.
- Stage S1 registers prod = x*y (2*MOD_W bits, unsigned), together with last, avail and side.
- Stage S2 is the pair accumulator. Its state machine has two states:
  - EMPTY (reset state):
    - prod valid and last=0: store prod in `acc_q`, go to HALF, no output.
    - prod valid and last=1: emit z = {1'b0, prod}, out_single=1, stay in EMPTY.
  - HALF:
    - prod valid (last is don't-care): emit z = acc_q + prod (full OP_W, no carry loss), out_single=0, go to EMPTY.
    - If last=1 in this case, the chunk ends cleanly after the pair.
- Cycles with avail=0 never change state. A HALF state may wait any number of idle cycles for its partner.
- `out_side` is the side data of the element that triggered the emit.
- Side data of a first-of-pair element is discarded.
- Arithmetic: the maximum sum is 2*(2^MOD_W-1)^2 < 2^(2*MOD_W+1). The result is exact, with no modular reduction.

## Timing
- Latency from the triggering element's `in_avail` to `out_avail`: IN_PIPE+2 cycles.
- Throughput: one element per cycle, back-to-back. Output rate is at most one word every two elements, or one word per cycle for back-to-back `last` elements.
- Reset values:
  - out_avail=0, out_single=0, z=0, state=EMPTY, acc_q=0.
  - All internal avail bits are 0.
  - out_side follows RST_SIDE.
- Reset asserted mid-pair: the stored half is discarded, state returns to EMPTY, and in-flight elements are dropped with no output.
- The first accepted element after reset deasserts always opens a new pair.
- z and out_single hold their last value when out_avail=0. Downstream must qualify on out_avail.

## Test plan
- MOD_W=33, IN_PIPE=1: inputs (3,5,0) then (7,11,0) on consecutive cycles -> one out_avail 3 cycles after the second element, z=92, out_single=0.
- Single element (2^33-1, 2^33-1, last=1) -> z=(2^33-1)^2, out_single=1, 3-cycle latency.
- Two max pairs (all-ones x and y), last=0 then last=1 -> z=2*(2^33-1)^2, bit 66 set, no truncation.
- Odd chunk of 3 elements: (1,1,0), (2,2,0), (3,3,1), then a new chunk (4,4,1) -> outputs z=5 (single=0), z=9 (single=1), z=16 (single=1). out_side matches the elements carrying 2, 3 and 4.
- Gap handling: (6,6,0), 10 idle cycles, (1,2,0) -> single output z=38. No output during the gap.
- Reset after the first of a pair (5,5,0), then (2,3,1) -> z=6, out_single=1. Every output is 0 and out_avail stays low while reset is held. IN_PIPE=0 is rerun with 2-cycle latency.

Source files
------------

// File: rtl/mod_mult_pair_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_mult_pair_acc: pipelined x*y with pairwise product summation           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mod_mult_pair_acc #(
  parameter int         MOD_W    = 33,
  parameter int         OP_W     = 2*MOD_W+1,
  parameter int         IN_PIPE  = 1,
  parameter int         SIDE_W   = 0,
  parameter logic [1:0] RST_SIDE = 2'b00
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [MOD_W-1:0]                    in_x,
  input  logic [MOD_W-1:0]                    in_y,
  input  logic                                in_last,
  input  logic                                in_avail,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
  output logic [OP_W-1:0]                     z,
  output logic                                out_single,
  output logic                                out_avail,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

  localparam int              SW           = (SIDE_W > 0) ? SIDE_W : 1;
  localparam int              PW           = 2*MOD_W;
  localparam bit              SIDE_HAS_RST = RST_SIDE[0] | RST_SIDE[1];
  localparam logic [SW-1:0]   SIDE_RST_VAL = RST_SIDE[0] ? {SW{1'b0}} : {SW{1'b1}};

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  if (OP_W != 2*MOD_W+1) begin : g_bad_op_w
    $fatal(1, "mod_mult_pair_acc: OP_W must equal 2*MOD_W+1");
  end

  // Operands as seen by the multiplier stage
  logic [MOD_W-1:0] a_x;
  logic [MOD_W-1:0] a_y;
  logic             a_last;
  logic             a_avail;
  logic [SW-1:0]    a_side;

  if (IN_PIPE == 1) begin : g_in_pipe
    logic [MOD_W-1:0] s0_x_d, s0_x_q;
    logic [MOD_W-1:0] s0_y_d, s0_y_q;
    logic             s0_last_d, s0_last_q;
    logic             s0_avail_d, s0_avail_q;
    logic [SW-1:0]    s0_side_d, s0_side_q;

    always_comb begin
      s0_x_d     = in_x;
      s0_y_d     = in_y;
      s0_last_d  = in_last;
      s0_avail_d = in_avail;
      s0_side_d  = in_side;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0_x_q     <= '0;
        s0_y_q     <= '0;
        s0_last_q  <= 1'b0;
        s0_avail_q <= 1'b0;
      end else begin
        s0_x_q     <= s0_x_d;
        s0_y_q     <= s0_y_d;
        s0_last_q  <= s0_last_d;
        s0_avail_q <= s0_avail_d;
      end
    end

    if (SIDE_HAS_RST) begin : g_s0_side_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) s0_side_q <= SIDE_RST_VAL;
        else     s0_side_q <= s0_side_d;
      end
    end else begin : g_s0_side_norst
      always_ff @(posedge clk) begin
        s0_side_q <= s0_side_d;
      end
    end

    assign a_x     = s0_x_q;
    assign a_y     = s0_y_q;
    assign a_last  = s0_last_q;
    assign a_avail = s0_avail_q;
    assign a_side  = s0_side_q;
  end else begin : g_no_in_pipe
    assign a_x     = in_x;
    assign a_y     = in_y;
    assign a_last  = in_last;
    assign a_avail = in_avail;
    assign a_side  = in_side;
  end

  logic [PW-1:0]   prod_d, prod_q;
  logic            s1_last_d, s1_last_q;
  logic            s1_avail_d, s1_avail_q;
  logic [SW-1:0]   s1_side_d, s1_side_q;

  state_t          state_d, state_q;
  logic [PW-1:0]   acc_d, acc_q;
  logic [OP_W-1:0] z_d, z_q;
  logic            out_single_d, out_single_q;
  logic            out_avail_d, out_avail_q;
  logic [SW-1:0]   out_side_d, out_side_q;

  always_comb begin
    prod_d     = PW'(a_x) * PW'(a_y);
    s1_last_d  = a_last;
    s1_avail_d = a_avail;
    s1_side_d  = a_side;
  end

  // Pair accumulator: first product of a pair is parked, second one emits the sum
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    z_d          = z_q;
    out_single_d = out_single_q;
    out_avail_d  = 1'b0;
    out_side_d   = out_side_q;
    if (s1_avail_q) begin
      case (state_q)
        EMPTY: begin
          if (s1_last_q) begin
            z_d          = {1'b0, prod_q};
            out_single_d = 1'b1;
            out_avail_d  = 1'b1;
            out_side_d   = s1_side_q;
          end else begin
            acc_d   = prod_q;
            state_d = HALF;
          end
        end
        HALF: begin
          z_d          = {1'b0, acc_q} + {1'b0, prod_q};
          out_single_d = 1'b0;
          out_avail_d  = 1'b1;
          out_side_d   = s1_side_q;
          state_d      = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q       <= '0;
      s1_last_q    <= 1'b0;
      s1_avail_q   <= 1'b0;
      state_q      <= EMPTY;
      acc_q        <= '0;
      z_q          <= '0;
      out_single_q <= 1'b0;
      out_avail_q  <= 1'b0;
    end else begin
      prod_q       <= prod_d;
      s1_last_q    <= s1_last_d;
      s1_avail_q   <= s1_avail_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      z_q          <= z_d;
      out_single_q <= out_single_d;
      out_avail_q  <= out_avail_d;
    end
  end

  if (SIDE_HAS_RST) begin : g_side_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_side_q  <= SIDE_RST_VAL;
        out_side_q <= SIDE_RST_VAL;
      end else begin
        s1_side_q  <= s1_side_d;
        out_side_q <= out_side_d;
      end
    end
  end else begin : g_side_norst
    always_ff @(posedge clk) begin
      s1_side_q  <= s1_side_d;
      out_side_q <= out_side_d;
    end
  end

  assign z          = z_q;
  assign out_single = out_single_q;
  assign out_avail  = out_avail_q;
  assign out_side   = out_side_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_mult_pair_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mod_mult_pair_acc: scoreboard bench, IN_PIPE=1 and IN_PIPE=0 side by side|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mod_mult_pair_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] in_x = '0;
  logic [32:0] in_y = '0;
  logic        in_last = 1'b0;
  logic        in_avail = 1'b0;
  logic [7:0]  in_side = '0;

  logic [66:0] z1, z0;
  logic        single1, single0, avail1, avail0;
  logic [7:0]  side1, side0;

  always #5 clk = ~clk;

  mod_mult_pair_acc #(.MOD_W(33), .OP_W(67), .IN_PIPE(1), .SIDE_W(8), .RST_SIDE(2'b01)) u_p1 (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .in_avail(in_avail), .in_side(in_side), .z(z1), .out_single(single1),
    .out_avail(avail1), .out_side(side1));

  mod_mult_pair_acc #(.MOD_W(33), .OP_W(67), .IN_PIPE(0), .SIDE_W(8), .RST_SIDE(2'b10)) u_p0 (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .in_avail(in_avail), .in_side(in_side), .z(z0), .out_single(single0),
    .out_avail(avail0), .out_side(side0));

  typedef struct {
    logic [66:0] z;
    logic        single;
    logic [7:0]  side;
    int          cyc;
  } exp_t;

  exp_t q [2][$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model state: a parked first-of-pair product
  bit          has_half = 1'b0;
  logic [65:0] half = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [32:0] x, input logic [32:0] y, input bit last,
                       input logic [7:0] side);
    logic [65:0] p;
    exp_t        e;
    p = 66'(x) * 66'(y);
    if (has_half) begin
      e.z      = 67'(half) + 67'(p);
      e.single = 1'b0;
      has_half = 1'b0;
    end else if (last) begin
      e.z      = 67'(p);
      e.single = 1'b1;
    end else begin
      has_half = 1'b1;
      half     = p;
      return;
    end
    e.side = side;
    e.cyc  = cyc + 3;
    q[1].push_back(e);
    e.cyc  = cyc + 2;
    q[0].push_back(e);
  endtask

  task automatic drive(input bit av, input logic [32:0] x, input logic [32:0] y,
                       input bit last, input logic [7:0] side);
    @(posedge clk);
    #1;
    in_avail = av;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    in_side  = side;
    if (av) model(x, y, last, side);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic mon(input int d, input logic av, input logic [66:0] zz, input logic s,
                     input logic [7:0] sd);
    exp_t  e;
    string tag;
    tag = (d == 1) ? "pipe1" : "pipe0";
    if (rst) begin
      check({tag, "_rst_avail"}, 67'(av), 67'd0);
      check({tag, "_rst_z"}, zz, 67'd0);
      check({tag, "_rst_single"}, 67'(s), 67'd0);
      check({tag, "_rst_side"}, 67'(sd), (d == 1) ? 67'h00 : 67'hFF);
    end else if (av) begin
      if (q[d].size() == 0) begin
        check({tag, "_unexpected_out"}, 67'(av), 67'd0);
      end else begin
        e = q[d].pop_front();
        check({tag, "_z"}, zz, e.z);
        check({tag, "_single"}, 67'(s), 67'(e.single));
        check({tag, "_side"}, 67'(sd), 67'(e.side));
        check({tag, "_latency_cycle"}, 67'(cyc), 67'(e.cyc));
      end
    end else if (q[d].size() > 0 && q[d][0].cyc <= cyc) begin
      e = q[d].pop_front();
      check({tag, "_missing_out_cycle"}, 67'(cyc), 67'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    mon(1, avail1, z1, single1, side1);
    mon(0, avail0, z0, single0, side0);
  end

  initial begin
    logic [32:0] max_v;
    logic [32:0] rx, ry;
    max_v = '1;

    idle(4);
    rst = 1'b0;

    drive(1'b1, 33'd3, 33'd5, 1'b0, 8'h11);
    drive(1'b1, 33'd7, 33'd11, 1'b0, 8'h12);
    idle(6);

    drive(1'b1, max_v, max_v, 1'b1, 8'h21);
    idle(6);

    drive(1'b1, max_v, max_v, 1'b0, 8'h31);
    drive(1'b1, max_v, max_v, 1'b1, 8'h32);
    idle(6);

    drive(1'b1, 33'd1, 33'd1, 1'b0, 8'h41);
    drive(1'b1, 33'd2, 33'd2, 1'b0, 8'h42);
    drive(1'b1, 33'd3, 33'd3, 1'b1, 8'h43);
    drive(1'b1, 33'd4, 33'd4, 1'b1, 8'h44);
    idle(6);

    drive(1'b1, 33'd6, 33'd6, 1'b0, 8'h51);
    idle(10);
    drive(1'b1, 33'd1, 33'd2, 1'b0, 8'h52);
    idle(6);

    // Reset while a first-of-pair product is parked
    drive(1'b1, 33'd5, 33'd5, 1'b0, 8'h61);
    idle(4);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    has_half = 1'b0;
    idle(3);
    rst = 1'b0;
    drive(1'b1, 33'd2, 33'd3, 1'b1, 8'h62);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rx = max_v;
        ry = max_v;
      end else begin
        rx = {1'($urandom_range(0, 1)), 32'($urandom)};
        ry = {1'($urandom_range(0, 1)), 32'($urandom)};
      end
      drive(($urandom_range(0, 9) < 7), rx, ry, ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    idle(10);

    check("pipe1_drain_pending", 67'(q[1].size()), 67'd0);
    check("pipe0_drain_pending", 67'(q[0].size()), 67'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
